rv_mc_sequencer: RTL and testbench
==================================

RV_MC_SEQUENCER -- requirements
Module: rv_mc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default shared-package ADDR_WIDTH (32), PC and instruction-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default shared-package DATA_WIDTH (32), instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value after reset.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum wait cycles per memory request.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 imem_req  output  1  instruction fetch request.
REQ-008 imem_addr  output  ADDR_WIDTH  fetch address; equals pc_current.
REQ-009 imem_ready  input  1  fetch complete, imem_rdata valid.
REQ-010 imem_rdata  input  DATA_WIDTH  fetched instruction.
REQ-011 inst  output  DATA_WIDTH  instruction register (IR) to decoder/regfile/imm gen.
REQ-012 pc_current  output  ADDR_WIDTH  architectural PC.
REQ-013 nextpc  input  ADDR_WIDTH  next PC from the next-PC generator.
REQ-014 mem_access  input  1  decoded current instruction is a load or store.
REQ-015 mem_write  input  1  decoded current instruction is a store.
REQ-016 dmem_req  output  1  data memory request.
REQ-017 dmem_we  output  1  data memory write strobe.
REQ-018 dmem_ready  input  1  data access complete.
REQ-019 reg_write  input  1  decoder register-write request.
REQ-020 reg_write_en  output  1  qualified register-file write enable.
REQ-021 retire  output  1  one-cycle pulse per completed instruction.
REQ-022 err  output  1  sticky memory-timeout error.

Function
REQ-023 SHALL implement states FETCH, EXEC, MEM, WB, ERR.
REQ-024 FETCH: imem_req=1; on imem_ready=1 latch imem_rdata into IR, go EXEC.
REQ-025 EXEC: no requests; mem_access=1 -> MEM, else -> WB.
REQ-026 MEM: dmem_req=1, dmem_we=mem_write; on dmem_ready=1 -> WB.
REQ-027 WB: reg_write_en=reg_write, retire=1, pc_current<=nextpc, -> FETCH; reg_write_en=0 in all other states.
REQ-028 Ready sampled same cycle as request (zero-wait allowed); ready while request low SHALL be ignored.
REQ-029 Zero-wait latency: non-memory instruction 3 cycles, load/store 4 cycles, retire-to-retire.
REQ-030 Wait counter SHALL clear on entry to FETCH/MEM, increment each cycle the request is pending without ready.
REQ-031 Counter reaching TIMEOUT without ready -> ERR; ready in the same cycle the counter hits TIMEOUT SHALL win (normal transition).
REQ-032 ERR: err=1, all requests/enables 0, PC and IR frozen, exit only by reset.
REQ-033 PC update SHALL take nextpc unmodified, ADDR_WIDTH bits, no alignment check.

Reset
REQ-034 On rst_n=0 immediately: state FETCH, pc_current=RESET_PC, inst=32'h0000_0013 (NOP), err=0, counter=0, retire=0, reg_write_en=0, dmem_req=0, dmem_we=0.
REQ-035 imem_req SHALL be 1 in the first cycle after rst_n deasserts.
REQ-036 Reset mid-request SHALL abort the access without a retire or register write.

Configuration
REQ-037 Macro RV_SEQ_PERF_CNT_EN defined: SHALL add outputs cycle_cnt and instret_cnt (32-bit each, reset 0, wrap at 2^32; cycle_cnt increments every non-reset cycle including ERR, instret_cnt on retire).
REQ-038 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-039 Shared package SHALL hold the state enum typedef, default TIMEOUT constant, and NOP encoding constant.
REQ-040 Wait/timeout counter SHALL be a sub-module rv_wait_timer (inputs start, pending, ready; output expired).

Verification
REQ-041 Reset release, imem_ready tied 1, ADDI instruction, nextpc=pc+4 -> retire every 3 cycles, pc 0,4,8.
REQ-042 LW with dmem_ready asserted after 2 wait cycles -> dmem_req held 3 cycles, retire at cycle 6, reg_write_en one pulse.
REQ-043 SW (mem_write=1, reg_write=0) zero-wait -> dmem_we=1 one cycle, reg_write_en stays 0, 4-cycle retire.
REQ-044 imem_ready held 0 with TIMEOUT=4 -> err=1 after 4 wait cycles, imem_req 0 thereafter, pc frozen.
REQ-045 dmem_ready asserted on the exact TIMEOUT cycle -> no ERR, normal WB.
REQ-046 rst_n pulsed low during MEM -> no retire, pc=RESET_PC, inst=0x00000013, fetch restarts; with RV_SEQ_PERF_CNT_EN both counters read 0.

Source files
------------

// File: rtl/rv_mc_sequencer_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
package rv_mc_sequencer_pkg;

    localparam int unsigned ADDR_WIDTH      = 32;
    localparam int unsigned DATA_WIDTH      = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam logic [31:0] NOP_INST        = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_ERR
    } seq_state_e;

endpackage

// File: rtl/rv_mc_sequencer_wait_timer.sv
// Wait-cycle counter for one outstanding memory request; flags expiry when the
// TIMEOUT-th consecutive wait cycle passes without ready.
module rv_wait_timer #(
    parameter int unsigned TIMEOUT = rv_mc_sequencer_pkg::TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic pending,
    input  logic ready,
    output logic expired
);

    localparam int unsigned     CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (pending && !ready) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // This wait cycle would take the count to TIMEOUT; ready in it still wins.
    assign expired = pending && !ready && (cnt_q == LAST);

endmodule

// File: rtl/rv_mc_sequencer.sv
// Multi-cycle RV fetch/execute/memory/writeback sequencer with memory timeout.
// Define RV_SEQ_PERF_CNT_EN to add cycle_cnt / instret_cnt performance counters.
module rv_mc_sequencer #(
    parameter int unsigned           ADDR_WIDTH = rv_mc_sequencer_pkg::ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH = rv_mc_sequencer_pkg::DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           TIMEOUT    = rv_mc_sequencer_pkg::TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] pc_current,
    input  logic [ADDR_WIDTH-1:0] nextpc,
    input  logic                  mem_access,
    input  logic                  mem_write,
    output logic                  dmem_req,
    output logic                  dmem_we,
    input  logic                  dmem_ready,
    input  logic                  reg_write,
    output logic                  reg_write_en,
    output logic                  retire,
    output logic                  err
`ifdef RV_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           cycle_cnt,
    output logic [31:0]           instret_cnt
`endif
);

    import rv_mc_sequencer_pkg::*;

    seq_state_e            state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] ir_q;
    logic                  imem_req_q;
    logic                  dmem_req_q;
    logic                  dmem_we_q;
    logic                  reg_write_en_q;
    logic                  retire_q;
    logic                  err_q;

    logic wait_start;
    logic wait_pending;
    logic wait_ready;
    logic wait_expired;

    // Clearing during EXEC/WB leaves the count at zero on entry to MEM/FETCH.
    assign wait_start   = (state_q == S_EXEC) || (state_q == S_WB);
    assign wait_pending = imem_req_q || dmem_req_q;
    assign wait_ready   = (imem_req_q && imem_ready) || (dmem_req_q && dmem_ready);

    rv_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (wait_start),
        .pending (wait_pending),
        .ready   (wait_ready),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_FETCH;
            pc_q           <= RESET_PC;
            ir_q           <= DATA_WIDTH'(NOP_INST);
            imem_req_q     <= 1'b1;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            reg_write_en_q <= 1'b0;
            retire_q       <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir_q       <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= S_EXEC;
                    end else if (wait_expired) begin
                        imem_req_q <= 1'b0;
                        err_q      <= 1'b1;
                        state_q    <= S_ERR;
                    end
                end
                S_EXEC: begin
                    if (mem_access) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= mem_write;
                        state_q    <= S_MEM;
                    end else begin
                        reg_write_en_q <= reg_write;
                        retire_q       <= 1'b1;
                        state_q        <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        dmem_req_q     <= 1'b0;
                        dmem_we_q      <= 1'b0;
                        reg_write_en_q <= reg_write;
                        retire_q       <= 1'b1;
                        state_q        <= S_WB;
                    end else if (wait_expired) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        err_q      <= 1'b1;
                        state_q    <= S_ERR;
                    end
                end
                S_WB: begin
                    pc_q           <= nextpc;
                    reg_write_en_q <= 1'b0;
                    retire_q       <= 1'b0;
                    imem_req_q     <= 1'b1;
                    state_q        <= S_FETCH;
                end
                S_ERR: begin
                    state_q <= S_ERR;
                end
                default: begin
                    imem_req_q     <= 1'b0;
                    dmem_req_q     <= 1'b0;
                    dmem_we_q      <= 1'b0;
                    reg_write_en_q <= 1'b0;
                    retire_q       <= 1'b0;
                    err_q          <= 1'b1;
                    state_q        <= S_ERR;
                end
            endcase
        end
    end

    assign imem_req     = imem_req_q;
    assign imem_addr    = pc_q;
    assign pc_current   = pc_q;
    assign inst         = ir_q;
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign reg_write_en = reg_write_en_q;
    assign retire       = retire_q;
    assign err          = err_q;

`ifdef RV_SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] instret_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (retire_q) begin
                instret_cnt_q <= instret_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_rv_mc_sequencer.sv
// Scoreboard bench for rv_mc_sequencer: drives a small decoder/memory model and
// compares each retirement against the expected PC, IR and write-enable count.
module tb_rv_mc_sequencer;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst;
    logic [31:0] pc_current;
    logic [31:0] nextpc;
    logic        mem_access;
    logic        mem_write;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready = 1'b0;
    logic        reg_write;
    logic        reg_write_en;
    logic        retire;
    logic        err;
`ifdef RV_SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    rv_mc_sequencer #(
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .pc_current   (pc_current),
        .nextpc       (nextpc),
        .mem_access   (mem_access),
        .mem_write    (mem_write),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .reg_write    (reg_write),
        .reg_write_en (reg_write_en),
        .retire       (retire),
        .err          (err)
`ifdef RV_SEQ_PERF_CNT_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Environment: next-PC generator and minimal decoder
    assign nextpc     = pc_current + 32'd4;
    assign mem_write  = (inst[6:0] == 7'b0100011);
    assign mem_access = (inst[6:0] == 7'b0000011) || mem_write;
    assign reg_write  = !mem_write;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        int          rwe;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_pc = '0;
    int          retired = 0;

    localparam logic [31:0] I_ADDI = 32'h0010_0093;
    localparam logic [31:0] I_LW   = 32'h0000_2103;
    localparam logic [31:0] I_SW   = 32'h0010_2023;
    localparam logic [31:0] I_NOP  = 32'h0000_0013;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Runs one instruction from FETCH until retire (or abort after abort_dreq MEM cycles).
    task automatic run_instr(input string tag, input logic [31:0] ins, input int iwait,
                             input int dwait, input int exp_cycles, input int exp_dreq,
                             input int exp_we, input int abort_dreq);
        exp_t e;
        int   cyc, icnt, dcnt, dreq, wec, rwec;
        bit   done;
        e.pc  = model_pc;
        e.ins = ins;
        e.rwe = (ins[6:0] == 7'b0100011) ? 0 : 1;
        if (abort_dreq == 0) sb.push_back(e);
        cyc = 0; icnt = 0; dcnt = 0; dreq = 0; wec = 0; rwec = 0; done = 0;
        while (!done && cyc < 60) begin
            cyc++;
            if (cyc == 1) begin
                check_eq({tag, " fetch_req"}, 64'(imem_req), 64'd1);
                check_eq({tag, " fetch_addr"}, 64'(imem_addr), 64'(model_pc));
            end
            imem_rdata = ins;
            imem_ready = imem_req ? (icnt >= iwait) : (iwait == 0);
            dmem_ready = dmem_req ? (dcnt >= dwait) : (dwait == 0);
            if (imem_req) icnt++;
            if (dmem_req) begin
                dcnt++;
                dreq++;
                if (dmem_we) wec++;
            end
            if (reg_write_en) rwec++;
            if (abort_dreq != 0 && dreq >= abort_dreq) return;
            if (retire) begin
                done = 1;
                if (sb.size() == 0) begin
                    check_eq({tag, " sb_empty"}, 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq({tag, " pc"}, 64'(pc_current), 64'(e.pc));
                    check_eq({tag, " inst"}, 64'(inst), 64'(e.ins));
                    check_eq({tag, " rwe_pulses"}, 64'(rwec), 64'(e.rwe));
                end
                check_eq({tag, " latency"}, 64'(cyc), 64'(exp_cycles));
                check_eq({tag, " dreq_cycles"}, 64'(dreq), 64'(exp_dreq));
                check_eq({tag, " we_cycles"}, 64'(wec), 64'(exp_we));
                check_eq({tag, " err"}, 64'(err), 64'd0);
                model_pc = model_pc + 32'd4;
                retired++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check_eq({tag, " no_retire"}, 64'd0, 64'd1);
        check_eq({tag, " retire_pulse"}, 64'(retire), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, " pc"}, 64'(pc_current), 64'd0);
        check_eq({tag, " inst"}, 64'(inst), 64'(I_NOP));
        check_eq({tag, " err"}, 64'(err), 64'd0);
        check_eq({tag, " retire"}, 64'(retire), 64'd0);
        check_eq({tag, " rwe"}, 64'(reg_write_en), 64'd0);
        check_eq({tag, " dreq"}, 64'(dmem_req), 64'd0);
        check_eq({tag, " dwe"}, 64'(dmem_we), 64'd0);
`ifdef RV_SEQ_PERF_CNT_EN
        check_eq({tag, " cycle_cnt"}, 64'(cycle_cnt), 64'd0);
        check_eq({tag, " instret_cnt"}, 64'(instret_cnt), 64'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [31:0] frozen_pc;
        int          reqc;
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_reset imem_req", 64'(imem_req), 64'd1);

        run_instr("addi0", I_ADDI, 0, 0, 3, 0, 0, 0);
        run_instr("addi1", I_ADDI, 0, 0, 3, 0, 0, 0);
        run_instr("addi2", I_ADDI, 0, 0, 3, 0, 0, 0);
        run_instr("lw_w2", I_LW, 0, 2, 6, 3, 0, 0);
        run_instr("sw_w0", I_SW, 0, 0, 4, 1, 1, 0);
        run_instr("lw_edge", I_LW, 0, 3, 7, 4, 0, 0);
        run_instr("addi_iw3", I_ADDI, 3, 0, 6, 0, 0, 0);
`ifdef RV_SEQ_PERF_CNT_EN
        check_eq("instret_cnt", 64'(instret_cnt), 64'(retired));
`endif

        // Abort a load in its second MEM cycle
        run_instr("abort", I_LW, 0, 100, 0, 0, 0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("abort_reset");
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("abort_sb_empty", 64'(sb.size()), 64'd0);
        model_pc = '0;
        run_instr("restart", I_ADDI, 0, 0, 3, 0, 0, 0);

        // Fetch never completes: timeout into ERR
        reqc = 0;
        for (int k = 0; k < 20 && !err; k++) begin
            imem_ready = 1'b0;
            if (imem_req) reqc++;
            @(posedge clk);
            #1;
        end
        check_eq("to_wait_cycles", 64'(reqc), 64'(TO));
        check_eq("to_err", 64'(err), 64'd1);
        frozen_pc = model_pc;
`ifdef RV_SEQ_PERF_CNT_EN
        begin
            logic [31:0] c0;
            c0 = cycle_cnt;
            repeat (5) begin
                imem_ready = 1'b1;
                dmem_ready = 1'b1;
                @(posedge clk);
                #1;
            end
            check_eq("err_cycle_cnt", 64'(cycle_cnt), 64'(c0 + 32'd5));
        end
`else
        repeat (5) begin
            imem_ready = 1'b1;
            dmem_ready = 1'b1;
            @(posedge clk);
            #1;
        end
`endif
        check_eq("err_sticky", 64'(err), 64'd1);
        check_eq("err_imem_req", 64'(imem_req), 64'd0);
        check_eq("err_dmem_req", 64'(dmem_req), 64'd0);
        check_eq("err_retire", 64'(retire), 64'd0);
        check_eq("err_rwe", 64'(reg_write_en), 64'd0);
        check_eq("err_pc_frozen", 64'(pc_current), 64'(frozen_pc));
        check_eq("err_inst_frozen", 64'(inst), 64'(I_ADDI));
        check_eq("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
